fetch_stage: RTL and testbench

- Front pipeline stage of the core.
- Generates the word-aligned program counter and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers variable-latency responses and presents one stage::InsnBundle per cycle to the Read stage.
- Handles downstream stall and branch/exception redirect, discarding wrong-path responses still in flight.

---
 rtl/stage.sv | 19 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage.sv
// stage: types and constants shared by the front-end pipeline stages.
package stage;

   localparam int unsigned FETCH_ADDR_WIDTH = 32;
   localparam int unsigned PC_WIDTH         = FETCH_ADDR_WIDTH - 2;
   localparam int unsigned INSN_WIDTH       = 32;
   localparam int unsigned FETCH_DEPTH      = 2;

   typedef logic [PC_WIDTH-1:0]   pc_t;
   typedef logic [INSN_WIDTH-1:0] insn_t;

   // One fetched instruction handed to the Read stage; addr is a word address.
   typedef struct packed {
      logic  valid;
      pc_t   addr;
      insn_t insn;
   } InsnBundle;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with push/pop/flush and an occupancy count.
// Read data is the current head (show-ahead); flush empties it in one cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      if (p == AW'(DEPTH - 1)) return '0;
      return p + AW'(1);
   endfunction

   assign o_data  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   // Storage write; data needs no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         if (i_push && !i_pop)      r_count <= r_count + CW'(1);
         else if (i_pop && !i_push) r_count <= r_count - CW'(1);
      end
   end

   // Callers must never overflow or underflow the queue.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush) begin
         assert (!(i_push && !i_pop && r_count == CW'(DEPTH)));
         assert (!(i_pop && r_count == '0));
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, in-order instruction memory requests and
// response buffering in front of the Read stage, with stall and redirect.
`ifndef MSG
`define MSG(LVL, ARGS)
`endif

module fetch_stage
   import stage::*;
#(
   parameter int unsigned           ADDR_WIDTH = stage::FETCH_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
   parameter int unsigned           DEPTH      = stage::FETCH_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-3:0] redirect_addr,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ADDR_WIDTH-3:0] req_addr,
   input  logic                  rsp_valid,
   input  logic [31:0]           rsp_data,
   output stage::InsnBundle      stage_out_insn
);

   localparam int unsigned     PW       = ADDR_WIDTH - 2;
   localparam int unsigned     CW       = $clog2(DEPTH + 1);
   localparam int unsigned     BW       = PW + INSN_WIDTH;
   localparam logic [PW-1:0]   RESET_PC = RESET_ADDR[ADDR_WIDTH-1:2];

   logic [PW-1:0]         r_pc;
   logic [CW-1:0]         r_outstanding;
   logic [CW-1:0]         r_kill_cnt;
   InsnBundle             r_out;

   logic                  w_credit;
   logic                  w_issue;
   logic                  w_rsp_live;
   logic                  w_out_load;
   logic                  w_buf_pop;
   logic [PW-1:0]         w_aq_head;
   logic                  w_aq_empty;
   logic [CW-1:0]         w_aq_count;
   logic [BW-1:0]         w_buf_head;
   logic                  w_buf_empty;
   logic [CW-1:0]         w_buf_count;
   logic [PW-1:0]         w_buf_addr;
   logic [INSN_WIDTH-1:0] w_buf_insn;

   // Outstanding requests (killed ones included) plus buffered responses
   // may never exceed DEPTH, so the buffer cannot overflow.
   assign w_credit   = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < (CW+1)'(DEPTH);
   assign req_valid  = !rst && !redirect_valid && w_credit;
   assign req_addr   = r_pc;
   assign w_issue    = req_valid && req_ready;

   // A response is live only when no wrong-path responses remain ahead of it.
   assign w_rsp_live = rsp_valid && (r_kill_cnt == '0) && !redirect_valid;

   assign w_out_load = !stall || !r_out.valid;
   assign w_buf_pop  = w_out_load && !w_buf_empty && !redirect_valid;
   assign w_buf_addr = w_buf_head[BW-1:INSN_WIDTH];
   assign w_buf_insn = w_buf_head[INSN_WIDTH-1:0];

   assign stage_out_insn = r_out;

   fetch_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_addr_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_issue),
      .i_pop   (w_rsp_live),
      .i_flush (redirect_valid),
      .i_data  (r_pc),
      .o_data  (w_aq_head),
      .o_empty (w_aq_empty),
      .o_count (w_aq_count)
   );

   fetch_fifo #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_rsp_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_rsp_live),
      .i_pop   (w_buf_pop),
      .i_flush (redirect_valid),
      .i_data  ({w_aq_head, rsp_data}),
      .o_data  (w_buf_head),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   // Program counter: redirect wins, otherwise advance on each accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_pc <= RESET_PC;
      else if (redirect_valid) r_pc <= redirect_addr;
      else if (w_issue)        r_pc <= r_pc + PW'(1);
   end

   // Requests in flight; issue and response in the same cycle cancel out.
   // No issue can happen in a redirect cycle, so this covers redirect too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         case ({w_issue, rsp_valid})
            2'b10:   r_outstanding <= r_outstanding + CW'(1);
            2'b01:   r_outstanding <= r_outstanding - CW'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // Wrong-path responses still to be discarded; a response arriving in the
   // redirect cycle is itself discarded, so it is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_kill_cnt <= '0;
      else if (redirect_valid)                  r_kill_cnt <= r_outstanding - CW'(rsp_valid);
      else if (rsp_valid && r_kill_cnt != '0)   r_kill_cnt <= r_kill_cnt - CW'(1);
   end

   // Output register toward Read: holds under stall, cleared by redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
      end else if (redirect_valid) begin
         r_out.valid <= 1'b0;
      end else if (w_out_load) begin
         if (!w_buf_empty) begin
            r_out.valid <= 1'b1;
            r_out.addr  <= PC_WIDTH'(w_buf_addr);
            r_out.insn  <= w_buf_insn;
            `MSG(5, ("FETCH: addr=%h op=%h", {w_buf_addr, 2'b00}, w_buf_insn));
         end else begin
            r_out.valid <= 1'b0;
         end
      end
   end

   // Memory protocol and internal bookkeeping invariants.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(rsp_valid && r_outstanding == '0));
         assert (!(w_rsp_live && w_aq_empty));
         assert (({1'b0, w_aq_count} + {1'b0, r_kill_cnt}) == {1'b0, r_outstanding});
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against an in-order memory
// model and an expected-address scoreboard on every consumed output.
module tb_fetch_stage;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              redirect_valid;
   logic [29:0]       redirect_addr;
   logic              req_valid;
   logic              req_ready;
   logic [29:0]       req_addr;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   stage::InsnBundle  stage_out_insn;

   typedef struct {
      logic [29:0] a;
      int unsigned due;
   } mreq_t;

   mreq_t            mq[$];
   int unsigned      cyc;
   int unsigned      lat;
   int unsigned      n_checks;
   int unsigned      n_errors;
   int unsigned      n_cons;
   int unsigned      target;
   logic [29:0]      exp_addr;
   logic             sb_en;
   logic             rnd_en;
   stage::InsnBundle held;

   fetch_stage #(
      .ADDR_WIDTH (32),
      .RESET_ADDR (32'h0000_0000),
      .DEPTH      (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .stage_out_insn (stage_out_insn)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f(input logic [29:0] a);
      return {2'b00, a} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at negedge, update the memory model after
   // the edge, then drive this cycle's memory response.
   task automatic cycle();
      logic        acc;
      logic        taken;
      logic [29:0] acc_a;
      int unsigned d;
      @(negedge clk);
      acc   = req_valid && req_ready;
      acc_a = req_addr;
      taken = rsp_valid;
      if (sb_en && !rst && !stall && !redirect_valid && stage_out_insn.valid) begin
         chk("sb_addr", 64'(stage_out_insn.addr), 64'(exp_addr));
         chk("sb_insn", 64'(stage_out_insn.insn), 64'(f(exp_addr)));
         exp_addr = exp_addr + 30'd1;
         n_cons++;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
      end else begin
         if (taken) mq.delete(0);
         if (acc) begin
            if (rnd_en) lat = $urandom_range(1, 4);
            d = cyc + lat;
            if (mq.size() != 0 && d <= mq[$].due) d = mq[$].due + 1;
            mq.push_back('{a: acc_a, due: d});
         end
      end
      cyc++;
      if (rnd_en) begin
         req_ready = ($urandom_range(0, 1) == 1);
         stall     = ($urandom_range(0, 3) == 0);
      end
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = f(mq[0].a);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
      req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0; lat = 1;
      n_checks = 0; n_errors = 0; n_cons = 0; cyc = 0; target = 0;
      exp_addr = '0; sb_en = 1'b0; rnd_en = 1'b0; held = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req_valid", 64'(req_valid), 64'(0));
      chk("rst_req_addr", 64'(req_addr), 64'(0));
      chk("rst_out_valid", 64'(stage_out_insn.valid), 64'(0));
      chk("rst_out_addr", 64'(stage_out_insn.addr), 64'(0));
      chk("rst_out_insn", 64'(stage_out_insn.insn), 64'(0));

      // Streaming with 1-cycle memory
      rst = 1'b0; cyc = 0; exp_addr = '0; sb_en = 1'b1;
      #1;
      chk("c0_req_valid", 64'(req_valid), 64'(1));
      chk("c0_req_addr", 64'(req_addr), 64'(0));
      chk("c0_out_valid", 64'(stage_out_insn.valid), 64'(0));
      cycle();
      chk("c1_req_valid", 64'(req_valid), 64'(1));
      chk("c1_req_addr", 64'(req_addr), 64'(1));
      cycle();
      chk("c2_req_valid", 64'(req_valid), 64'(0));
      chk("c2_out_valid", 64'(stage_out_insn.valid), 64'(0));
      cycle();
      chk("c3_out_valid", 64'(stage_out_insn.valid), 64'(1));
      chk("c3_out_addr", 64'(stage_out_insn.addr), 64'(0));
      chk("c3_out_insn", 64'(stage_out_insn.insn), 64'(32'h1234_5678));
      chk("c3_req_addr", 64'(req_addr), 64'(2));
      cycle();
      chk("c4_out_valid", 64'(stage_out_insn.valid), 64'(1));
      chk("c4_out_addr", 64'(stage_out_insn.addr), 64'(1));
      chk("c4_out_insn", 64'(stage_out_insn.insn), 64'(32'h1234_5679));
      chk("c4_req_addr", 64'(req_addr), 64'(3));
      cycle();
      chk("c5_out_valid", 64'(stage_out_insn.valid), 64'(0));
      chk("c5_req_valid", 64'(req_valid), 64'(0));

      // Stall mid-stream: output frozen, issue stops at full credit
      for (int i = 0; i < 10 && !stage_out_insn.valid; i++) cycle();
      chk("st_wait_valid", 64'(stage_out_insn.valid), 64'(1));
      stall = 1'b1;
      held  = stage_out_insn;
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk("st_hold", 64'(stage_out_insn), 64'(held));
      end
      chk("st_req_valid", 64'(req_valid), 64'(0));
      stall = 1'b0;
      repeat (12) cycle();

      // Redirect with two requests in flight, 3-cycle memory
      lat = 3;
      for (int i = 0; i < 30 && !(mq.size() == 2 && !rsp_valid); i++) cycle();
      chk("r1_wait", 64'(mq.size() == 2 && !rsp_valid), 64'(1));
      redirect_valid = 1'b1; redirect_addr = 30'h100; exp_addr = 30'h100;
      #1;
      chk("r1_no_issue", 64'(req_valid), 64'(0));
      cycle();
      redirect_valid = 1'b0;
      #1;
      chk("r1_req_addr", 64'(req_addr), 64'(30'h100));
      chk("r1_out_valid", 64'(stage_out_insn.valid), 64'(0));
      for (int i = 0; i < 30 && !stage_out_insn.valid; i++) cycle();
      chk("r1_first_addr", 64'(stage_out_insn.addr), 64'(30'h100));
      chk("r1_first_insn", 64'(stage_out_insn.insn), 64'(f(30'h100)));
      repeat (10) cycle();

      // Redirect with a response in the same cycle while stalled
      for (int i = 0; i < 30 && !(mq.size() == 2 && rsp_valid); i++) cycle();
      chk("r2_wait", 64'(mq.size() == 2 && rsp_valid), 64'(1));
      stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 30'h200; exp_addr = 30'h200;
      #1;
      chk("r2_no_issue", 64'(req_valid), 64'(0));
      cycle();
      redirect_valid = 1'b0; stall = 1'b0;
      #1;
      chk("r2_out_valid", 64'(stage_out_insn.valid), 64'(0));
      chk("r2_req_addr", 64'(req_addr), 64'(30'h200));
      for (int i = 0; i < 30 && !stage_out_insn.valid; i++) cycle();
      chk("r2_first_addr", 64'(stage_out_insn.addr), 64'(30'h200));
      repeat (10) cycle();

      // Back-to-back redirects: last one wins
      lat = 2;
      redirect_valid = 1'b1; redirect_addr = 30'h1000; exp_addr = 30'h1000;
      cycle();
      redirect_addr = 30'h2000; exp_addr = 30'h2000;
      cycle();
      redirect_valid = 1'b0;
      #1;
      chk("bb_req_addr", 64'(req_addr), 64'(30'h2000));
      for (int i = 0; i < 30 && !stage_out_insn.valid; i++) cycle();
      chk("bb_first_addr", 64'(stage_out_insn.addr), 64'(30'h2000));
      repeat (6) cycle();

      // PC wrap at the top of the word address space
      lat = 1;
      redirect_valid = 1'b1; redirect_addr = 30'h3FFF_FFFF; exp_addr = 30'h3FFF_FFFF;
      cycle();
      redirect_valid = 1'b0;
      #1;
      for (int i = 0; i < 10 && !req_valid; i++) cycle();
      chk("wrap_req_valid", 64'(req_valid), 64'(1));
      chk("wrap_req_top", 64'(req_addr), 64'(30'h3FFF_FFFF));
      cycle();
      chk("wrap_req_zero", 64'(req_addr), 64'(0));
      repeat (10) cycle();

      // Random ready, latency and stall; 1000 consecutive instructions
      rnd_en = 1'b1;
      redirect_valid = 1'b1; redirect_addr = 30'h0001_0000; exp_addr = 30'h0001_0000;
      cycle();
      redirect_valid = 1'b0;
      target = n_cons + 1000;
      for (int i = 0; i < 30000 && n_cons < target; i++) cycle();
      chk("rand_done", 64'(n_cons >= target), 64'(1));
      rnd_en = 1'b0; stall = 1'b0; req_ready = 1'b1; lat = 1;

      // Reset mid-operation
      rst = 1'b1; mq.delete(); rsp_valid = 1'b0; rsp_data = '0;
      #1;
      chk("mr_req_valid", 64'(req_valid), 64'(0));
      chk("mr_out_valid", 64'(stage_out_insn.valid), 64'(0));
      chk("mr_out_addr", 64'(stage_out_insn.addr), 64'(0));
      chk("mr_out_insn", 64'(stage_out_insn.insn), 64'(0));
      chk("mr_req_addr", 64'(req_addr), 64'(0));
      cycle();
      cycle();
      rst = 1'b0; exp_addr = '0;
      #1;
      chk("mr_restart_valid", 64'(req_valid), 64'(1));
      chk("mr_restart_addr", 64'(req_addr), 64'(0));
      for (int i = 0; i < 10 && !stage_out_insn.valid; i++) cycle();
      chk("mr_first_addr", 64'(stage_out_insn.addr), 64'(0));
      chk("mr_first_insn", 64'(stage_out_insn.insn), 64'(32'h1234_5678));
      repeat (6) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
